// File: rtl/mux2_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 data mux.
// Grants are registered; a contested grant is pre-empted after MAX_HOLD cycles.
module mux2_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int CW   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam int CMAX = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;
    logic          sel_q, sel_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          hold_up;

    assign hold_up = (MAX_HOLD != 0) && (cnt_q == CNT_MAX);

    // Next grant state, grant age, last-granted pointer and select.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        gnt_d   = 2'b00;

        case (state_q)
            IDLE: begin
                case (req)
                    2'b01:   state_d = G0;
                    2'b10:   state_d = G1;
                    2'b11:   state_d = ptr_q ? G0 : G1;
                    default: state_d = IDLE;
                endcase
            end
            G0: begin
                if (!req[0] && req[1])
                    state_d = G1;
                else if (!req[0])
                    state_d = IDLE;
                else if (req[1] && hold_up)
                    state_d = G1;
            end
            G1: begin
                if (!req[1] && req[0])
                    state_d = G0;
                else if (!req[1])
                    state_d = IDLE;
                else if (req[0] && hold_up)
                    state_d = G0;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            cnt_d = '0;
        else if (state_q != IDLE && cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;

        if (state_d == G0) begin
            ptr_d = 1'b0;
            sel_d = 1'b0;
            gnt_d = 2'b01;
        end else if (state_d == G1) begin
            ptr_d = 1'b1;
            sel_d = 1'b1;
            gnt_d = 2'b10;
        end
    end

    // State register; reset clears outputs without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            sel_q   <= 1'b0;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = |gnt_q;
    assign out_data  = out_valid ? (sel_q ? data_b : data_a) : '0;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: vector table plus reset and
// no-pre-emption sequences.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [7:0] data_a = 8'hA5;
    logic [7:0] data_b = 8'h3C;
    logic [1:0] gnt;
    logic       sel;
    logic       out_valid;
    logic [7:0] out_data;

    logic       rst_n0;
    logic [1:0] req_n0;
    logic [1:0] gnt_n0;
    logic       sel_n0;
    logic       vld_n0;
    logic [7:0] dat_n0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(8), .MAX_HOLD(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    mux2_arbiter #(.WIDTH(8), .MAX_HOLD(0)) u_nohold (
        .clk       (clk),
        .rst       (rst_n0),
        .req       (req_n0),
        .data_a    (data_a),
        .data_b    (data_b),
        .gnt       (gnt_n0),
        .sel       (sel_n0),
        .out_valid (vld_n0),
        .out_data  (dat_n0)
    );

    typedef struct {
        logic [1:0] req;
        logic [1:0] gnt;
        logic       sel;
        logic [7:0] dat;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] r, input logic [1:0] g,
                       input logic s, input logic [7:0] d, input int n);
        vec_t v;
        v.req = r;
        v.gnt = g;
        v.sel = s;
        v.dat = d;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic step(input logic [1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 2'b00;
        rst_n0 = 1'b1;
        req_n0 = 2'b00;

        // single requester, then release
        add(2'b10, 2'b10, 1'b1, 8'h3C, 10);
        add(2'b00, 2'b00, 1'b1, 8'h00, 1);
        // contention: 4/4/4
        add(2'b11, 2'b01, 1'b0, 8'hA5, 4);
        add(2'b11, 2'b10, 1'b1, 8'h3C, 4);
        add(2'b11, 2'b01, 1'b0, 8'hA5, 4);
        add(2'b00, 2'b00, 1'b0, 8'h00, 1);
        // round-robin from idle
        add(2'b01, 2'b01, 1'b0, 8'hA5, 2);
        add(2'b00, 2'b00, 1'b0, 8'h00, 1);
        add(2'b11, 2'b10, 1'b1, 8'h3C, 1);
        add(2'b00, 2'b00, 1'b1, 8'h00, 1);
        add(2'b10, 2'b10, 1'b1, 8'h3C, 2);
        add(2'b00, 2'b00, 1'b1, 8'h00, 1);
        add(2'b11, 2'b01, 1'b0, 8'hA5, 1);
        add(2'b00, 2'b00, 1'b0, 8'h00, 1);
        // hand-over at cnt=1, then full G1 window
        add(2'b01, 2'b01, 1'b0, 8'hA5, 1);
        add(2'b11, 2'b01, 1'b0, 8'hA5, 1);
        add(2'b10, 2'b10, 1'b1, 8'h3C, 1);
        add(2'b11, 2'b10, 1'b1, 8'h3C, 3);
        add(2'b11, 2'b01, 1'b0, 8'hA5, 1);
        add(2'b00, 2'b00, 1'b0, 8'h00, 1);
        // release coinciding with pre-emption point
        add(2'b01, 2'b01, 1'b0, 8'hA5, 1);
        add(2'b11, 2'b01, 1'b0, 8'hA5, 3);
        add(2'b10, 2'b10, 1'b1, 8'h3C, 2);
        add(2'b00, 2'b00, 1'b1, 8'h00, 1);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 0, 32'(gnt), 32'h0);
        chk("rst_sel", 0, 32'(sel), 32'h0);
        chk("rst_vld", 0, 32'(out_valid), 32'h0);
        chk("rst_dat", 0, 32'(out_data), 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        rst_n0 = 1'b0;

        foreach (vq[i]) begin
            step(vq[i].req);
            chk("gnt", i, 32'(gnt), 32'(vq[i].gnt));
            chk("sel", i, 32'(sel), 32'(vq[i].sel));
            chk("vld", i, 32'(out_valid), 32'(|vq[i].gnt));
            chk("dat", i, 32'(out_data), 32'(vq[i].dat));
        end

        // asynchronous reset in the middle of a G1 grant
        step(2'b10);
        chk("pre_gnt", 0, 32'(gnt), 32'h2);
        #3;
        rst = 1'b1;
        #1;
        chk("async_gnt", 0, 32'(gnt), 32'h0);
        chk("async_sel", 0, 32'(sel), 32'h0);
        chk("async_vld", 0, 32'(out_valid), 32'h0);
        chk("async_dat", 0, 32'(out_data), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(2'b11);
        chk("tie_gnt", 0, 32'(gnt), 32'h1);
        chk("tie_dat", 0, 32'(out_data), 32'hA5);
        step(2'b00);

        // MAX_HOLD=0: no pre-emption under contention
        for (int i = 0; i < 20; i++) begin
            req_n0 = 2'b11;
            @(posedge clk);
            #1;
            chk("nh_gnt", i, 32'(gnt_n0), 32'h1);
            chk("nh_dat", i, 32'(dat_n0), 32'hA5);
        end
        req_n0 = 2'b10;
        @(posedge clk);
        #1;
        chk("nh_hand", 0, 32'(gnt_n0), 32'h2);
        chk("nh_hdat", 0, 32'(dat_n0), 32'h3C);
        chk("nh_sel", 0, 32'(sel_n0), 32'h1);
        chk("nh_vld", 0, 32'(vld_n0), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Sequential arbiter that shares one 2:1 data multiplexer between two requesters. It drives the mux select from a registered grant state machine with round-robin tie-breaking and a bounded hold time, so neither requester can starve the other. The selected data is presented on a single output with a valid flag. It sits directly in front of the shared 2:1 mux datapath and is the only source of its select line.

## Interface

Parameters:
- `WIDTH`, default 8: data width of each requester and of the output.
- `MAX_HOLD`, default 4: minimum guaranteed grant length in cycles, and the point at which a contested grant is pre-empted. 0 disables pre-emption.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 2: `req[i]` high while requester i wants the mux.
- `data_a`, input, WIDTH: requester 0 data, mux input 0.
- `data_b`, input, WIDTH: requester 1 data, mux input 1.
- `gnt`, output, 2: one-hot grant (registered); 2'b00 when idle.
- `sel`, output, 1: mux select (registered); 0 selects `data_a`, 1 selects `data_b`.
- `out_valid`, output, 1: `|gnt`.
- `out_data`, output, WIDTH: `sel ? data_b : data_a` when `out_valid`, else 0 (combinational from registered `sel`).

## Operation

- States: IDLE, G0, G1. Internal `ptr` holds the last-granted index. Internal `cnt` holds the grant age, with width `$clog2(MAX_HOLD+1)` (minimum 1).
- IDLE:
  - `req=01` → G0.
  - `req=10` → G1.
  - `req=11` → grant the requester that is not `ptr`.
  - `req=00` → stay in IDLE.
- G0, evaluated in order:
  - `!req[0] && req[1]` → G1 (direct hand-over, no idle cycle).
  - `!req[0]` → IDLE.
  - `req[1] && MAX_HOLD!=0 && cnt==MAX_HOLD-1` → G1 (pre-emption).
  - Otherwise stay in G0.
- G1: mirror of G0 with the indices swapped.
- `cnt`:
  - Cleared on any state change.
  - Increments each cycle spent in G0/G1.
  - Saturates at `MAX_HOLD-1`, or at 0 when `MAX_HOLD=0`.
- `ptr` updates to i on every entry into Gi.
- Outputs from state:
  - G0 → `gnt=01`, `sel=0`.
  - G1 → `gnt=10`, `sel=1`.
  - IDLE → `gnt=00`, `sel` holds its last value.
- Requesters are not acknowledged separately; `gnt[i]` is the acknowledgement. A requester may drop `req` at any time. Its grant ends at the next edge.

## Timing

- Reset values while `rst` is high, asynchronously: state=IDLE, `gnt=00`, `sel=0`, `ptr=1` (requester 0 wins the first tie), `cnt=0`, `out_valid=0`, `out_data=0`.
- Latency: `req` sampled at edge k → `gnt`/`sel` valid after edge k. `out_data` follows `sel` in the same cycle. Data changes on the granted input pass through combinationally.
- Release latency: `req[i]` dropped before edge k → `gnt[i]=0` after edge k.
- Contested grant: the holder keeps the grant exactly `MAX_HOLD` cycles, then switches to the other requester if it is still requesting.
- Uncontested grant: held indefinitely; `cnt` stays saturated.
- Pre-emption and the requester's own release in the same cycle: treated as a hand-over, with identical result.
- Both requests dropping in the same cycle → IDLE, `sel` unchanged.
- `MAX_HOLD=1` with both requesting continuously: the grant alternates every cycle.
- `rst` asserted mid-grant: outputs clear immediately, without waiting for a clock edge. After release, the first tie goes to requester 0.

## Test plan

Use `WIDTH=8`, `MAX_HOLD=4`, `data_a=8'hA5`, `data_b=8'h3C` for all scenarios.

1. **Reset:** assert `rst` mid-cycle.
   - `gnt=00`, `sel=0`, `out_valid=0`, `out_data=00` with no clock edge.
   - After release with `req=11`: `gnt=01` after the first edge.
2. **Single requester:** `req=10` held for 10 cycles, then `00`.
   - `gnt=10`, `sel=1`, `out_data=3C` for 10 cycles, then `gnt=00`, `out_data=00`.
   - No pre-emption.
3. **Contention:** `req=11` held continuously.
   - `gnt` sequence: 01×4, 10×4, 01×4.
   - `out_data` sequence: A5×4, 3C×4, A5×4.
4. **Hand-over:** in G0 with `req=11` at `cnt=1`, drop `req[0]`.
   - Next cycle `gnt=10` with no `00` gap.
   - `cnt` restarts, so G1 lasts a full 4 cycles if `req[0]` returns.
5. **Round-robin from idle:**
   - `req=01` for 2 cycles, then `00` for 1, then `11` → G1 wins (`ptr=0`).
   - Repeat the same pattern ending in G1 → the next tie goes to G0.
6. **Pre-emption disabled:** `MAX_HOLD=0`, `req=11` held for 20 cycles.
   - `gnt` stays `01` throughout.
   - Dropping `req[0]` → `gnt=10` next cycle.
